// File: rtl/access_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : access_decode_if
// Description : Host-side bus bundle for access_decode. It carries the word
//               address, the request strobe, the target selects and the
//               completion status.
// Revision    : 1.0  initial release
// ============================================================================
interface access_decode_if #(
    parameter int AW  = 14,
    parameter int NIO = 7
);
    logic [AW-1:2]  a;
    logic           stb;
    logic           rom_cs;
    logic [NIO-1:0] io_cs;
    logic           ack;
    logic           err;
    logic           busy;

    modport master (output a, stb, input rom_cs, io_cs, ack, err, busy);
    modport slave  (input a, stb, output rom_cs, io_cs, ack, err, busy);
endinterface
`default_nettype wire

// File: rtl/access_decode.sv
`default_nettype none
// ============================================================================
// Module      : access_decode
// Description : Address decoder and wait-state sequencer. Selects ROM or one
//               of NIO I/O regions, counts per-target wait states, then
//               issues a one-cycle ack (with err for unmapped accesses).
// Revision    : 1.0  initial release
// ============================================================================
module access_decode #(
    parameter int AW   = 14,
    parameter int IDXW = 3,
    parameter int NIO  = 7,
    parameter int WSW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    access_decode_if.slave         bus,
    input  logic [(NIO+1)*WSW-1:0] wait_cfg,
    input  logic [NIO-1:0]         en_mask
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]     state, state_n;
    logic [WSW-1:0] count, count_n;
    logic           pend, pend_n;     // unmapped access waiting for its ack
    logic           rom_sel, rom_sel_n;
    logic [NIO-1:0] io_sel, io_sel_n;
    logic           ack_flag, ack_flag_n;
    logic           err_flag, err_flag_n;
    logic           busy_flag, busy_flag_n;

    logic [IDXW-1:0] idx;
    logic            is_rom;
    logic [NIO-1:0]  io_hit;
    logic [WSW-1:0]  io_wait;
    logic            unused_addr;

    assign is_rom      = ~bus.a[AW-1];
    assign idx         = bus.a[AW-2 -: IDXW];
    assign unused_addr = ^bus.a;

    // Region match against the enable mask, and the wait count of the hit slot
    always_comb begin
        io_hit  = '0;
        io_wait = '0;
        for (int k = 0; k < NIO; k++) begin
            if (idx == IDXW'(k) && en_mask[k]) begin
                io_hit[k] = 1'b1;
                io_wait   = wait_cfg[(k+1)*WSW +: WSW];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n    = state;
        count_n    = count;
        pend_n     = pend;
        rom_sel_n  = rom_sel;
        io_sel_n   = io_sel;
        ack_flag_n = 1'b0;
        err_flag_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.stb) begin
                    // Unmapped accesses ride through WAIT with a zero count so
                    // their ack lands one edge after acceptance, like W=0.
                    state_n = WAIT;
                    if (is_rom) begin
                        rom_sel_n = 1'b1;
                        count_n   = wait_cfg[WSW-1:0];
                    end else if (|io_hit) begin
                        io_sel_n  = io_hit;
                        count_n   = io_wait;
                    end else begin
                        pend_n    = 1'b1;
                        count_n   = '0;
                    end
                end
            end
            WAIT: begin
                if (!bus.stb && !pend) begin
                    state_n   = IDLE;
                    rom_sel_n = 1'b0;
                    io_sel_n  = '0;
                    count_n   = '0;
                end else if (count == '0) begin
                    state_n    = ACK;
                    ack_flag_n = 1'b1;
                    err_flag_n = pend;
                    pend_n     = 1'b0;
                end else begin
                    count_n = count - WSW'(1);
                end
            end
            ACK: begin
                state_n = HOLD;
            end
            default: begin
                if (!bus.stb) begin
                    state_n   = IDLE;
                    rom_sel_n = 1'b0;
                    io_sel_n  = '0;
                end
            end
        endcase
        busy_flag_n = (state_n != IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            pend      <= 1'b0;
            rom_sel   <= 1'b0;
            io_sel    <= '0;
            ack_flag  <= 1'b0;
            err_flag  <= 1'b0;
            busy_flag <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            pend      <= pend_n;
            rom_sel   <= rom_sel_n;
            io_sel    <= io_sel_n;
            ack_flag  <= ack_flag_n;
            err_flag  <= err_flag_n;
            busy_flag <= busy_flag_n;
        end
    end

    assign bus.rom_cs = rom_sel;
    assign bus.io_cs  = io_sel;
    assign bus.ack    = ack_flag;
    assign bus.err    = err_flag;
    assign bus.busy   = busy_flag;
endmodule
`default_nettype wire

// File: tb/tb_access_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_access_decode
// Description : Self-checking bench for access_decode: directed scenarios,
//               randomized accesses against a behavioural model, and a wide
//               parameter instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_access_decode;
    localparam int AW0 = 14, IDXW0 = 3, NIO0 = 7,  WSW0 = 4;
    localparam int AW1 = 16, IDXW1 = 4, NIO1 = 12, WSW1 = 6;

    logic clk;
    logic rst_n;
    logic [(NIO0+1)*WSW0-1:0] wait_cfg0;
    logic [NIO0-1:0]          en_mask0;
    logic [(NIO1+1)*WSW1-1:0] wait_cfg1;
    logic [NIO1-1:0]          en_mask1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    access_decode_if #(.AW(AW0), .NIO(NIO0)) bus0 ();
    access_decode_if #(.AW(AW1), .NIO(NIO1)) bus1 ();

    access_decode #(.AW(AW0), .IDXW(IDXW0), .NIO(NIO0), .WSW(WSW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .wait_cfg(wait_cfg0), .en_mask(en_mask0));
    access_decode #(.AW(AW1), .IDXW(IDXW1), .NIO(NIO1), .WSW(WSW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .wait_cfg(wait_cfg1), .en_mask(en_mask1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what an access at this address should do, from the decode rules
    function automatic void model(input int addr, input int en, input logic [31:0] wcfg,
                                  output bit rom, output int io, output int w, output bit unm);
        int idx;
        int slot;
        rom  = (addr < (1 << (AW0 - 3)));
        idx  = (addr >> (AW0 - 3 - IDXW0)) % (1 << IDXW0);
        unm  = !rom && (idx >= NIO0 || ((en >> idx) & 1) == 0);
        io   = (rom || unm) ? 0 : (1 << idx);
        slot = rom ? 0 : idx + 1;
        w    = unm ? 0 : int'((wcfg >> (WSW0 * slot)) & ((1 << WSW0) - 1));
    endfunction

    task automatic test_reset();
        logic [10:0] got;
        got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
        chk_cnt++;
        if (got !== 11'b0) $display("FAIL reset_async got=%b exp=%b", got, 11'b0);
        else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
        chk_cnt++;
        if (got !== 11'b0) $display("FAIL reset_idle got=%b exp=%b", got, 11'b0);
        else pass_cnt++;
    endtask

    // One full access on the default instance, checked every cycle against the model
    task automatic test_access(input string name, input int addr, input int en,
                               input logic [31:0] wcfg, input int hold_extra, input bit scramble);
        bit rom, unm;
        int io, w;
        logic [10:0] got, exp;
        model(addr, en, wcfg, rom, io, w, unm);
        @(negedge clk);
        bus0.a = 12'(addr); bus0.stb = 1'b1; en_mask0 = 7'(en); wait_cfg0 = wcfg;
        for (int j = 0; j <= w + 1; j++) begin
            @(negedge clk);
            if (scramble) begin
                bus0.a = 12'($urandom); en_mask0 = 7'($urandom); wait_cfg0 = $urandom;
            end
            got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
            exp = {rom, 7'(io), (j == w + 1), (j == w + 1) && unm, 1'b1};
            chk_cnt++;
            if (got !== exp) $display("FAIL %s cyc=%0d got=%b exp=%b", name, j, got, exp);
            else pass_cnt++;
        end
        for (int h = 0; h < hold_extra; h++) begin
            @(negedge clk);
            got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
            exp = {rom, 7'(io), 2'b00, 1'b1};
            chk_cnt++;
            if (got !== exp) $display("FAIL %s_hold h=%0d got=%b exp=%b", name, h, got, exp);
            else pass_cnt++;
        end
        bus0.stb = 1'b0;
        if (hold_extra == 0) begin
            @(negedge clk);
            got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
            exp = {rom, 7'(io), 2'b00, 1'b1};
            chk_cnt++;
            if (got !== exp) $display("FAIL %s_hold got=%b exp=%b", name, got, exp);
            else pass_cnt++;
        end
        @(negedge clk);
        got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
        chk_cnt++;
        if (got !== 11'b0) $display("FAIL %s_release got=%b exp=%b", name, got, 11'b0);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        test_access("rom_read",  32'h100, 32'h7F, 32'h0000_0002, 1, 0);
        test_access("io_read",   32'hD00, 32'h7F, 32'h0000_0003, 0, 0);
        test_access("unmap_idx7", 32'hF00, 32'h7F, 32'h5555_5555, 0, 0);
        test_access("unmap_dis2", 32'hA00, 32'h7B, 32'h5555_5555, 2, 0);
        test_access("back_to_back", 32'h9FF, 32'h7F, 32'h0000_0400, 0, 0);
    endtask

    task automatic test_abort();
        logic [10:0] got;
        @(negedge clk);
        bus0.a = 12'h100; bus0.stb = 1'b1; wait_cfg0 = 32'h5; en_mask0 = 7'h7F;
        @(negedge clk);
        chk_cnt++;
        if (bus0.rom_cs !== 1'b1) $display("FAIL abort_sel got=%b exp=1", bus0.rom_cs);
        else pass_cnt++;
        @(negedge clk);
        bus0.stb = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
            chk_cnt++;
            if (got !== 11'b0) $display("FAIL abort cyc=%0d got=%b exp=%b", j, got, 11'b0);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] got;
        @(negedge clk);
        bus0.a = 12'hC00; bus0.stb = 1'b1; wait_cfg0 = 32'h0000_0050; en_mask0 = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if (bus0.busy !== 1'b1) $display("FAIL arst_busy got=%b exp=1", bus0.busy);
        else pass_cnt++;
        #2 rst_n = 1'b0; bus0.stb = 1'b0;
        #1;
        got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
        chk_cnt++;
        if (got !== 11'b0) $display("FAIL arst_now got=%b exp=%b", got, 11'b0);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            got = {bus0.rom_cs, bus0.io_cs, bus0.ack, bus0.err, bus0.busy};
            chk_cnt++;
            if (got !== 11'b0) $display("FAIL arst_after cyc=%0d got=%b exp=%b", j, got, 11'b0);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            test_access("random", int'($urandom_range(0, 4095)), int'($urandom_range(0, 127)),
                        $urandom, int'($urandom_range(0, 2)), 1);
    endtask

    task automatic test_sweep();
        logic [NIO1+2:0] got, exp;
        wait_cfg1 = '1;
        en_mask1  = '1;
        for (int k = 0; k < NIO1; k++) begin
            @(negedge clk);
            bus1.a = 14'((1 << 13) | (k << 9) | int'($urandom_range(0, 511)));
            bus1.stb = 1'b1;
            for (int j = 0; j <= 64; j++) begin
                @(negedge clk);
                got = {bus1.rom_cs, bus1.io_cs, bus1.ack, bus1.busy};
                exp = {1'b0, 12'(1 << k), (j == 64), 1'b1};
                chk_cnt++;
                if (got !== exp) $display("FAIL sweep k=%0d cyc=%0d got=%b exp=%b", k, j, got, exp);
                else pass_cnt++;
            end
            bus1.stb = 1'b0;
            @(negedge clk);
            @(negedge clk);
            got = {bus1.rom_cs, bus1.io_cs, bus1.ack, bus1.busy};
            chk_cnt++;
            if (got !== '0) $display("FAIL sweep_release k=%0d got=%b exp=0", k, got);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.a = '0; bus0.stb = 1'b0; wait_cfg0 = '0; en_mask0 = '0;
        bus1.a = '0; bus1.stb = 1'b0; wait_cfg1 = '0; en_mask1 = '0;
        #1;
        test_reset();
        test_directed();
        test_abort();
        test_async_reset();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire
